// File: rtl/pkg_const_streamer_pkg.sv
// Shared definitions for the constant-table streamer: table geometry, FSM
// states, entry record and the lookup/beat helpers used by the top.
package pkg_const_streamer_pkg;

  localparam int unsigned MAX_W       = 128;
  localparam int unsigned NUM_ENTRIES = 6;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_e;

  typedef struct packed {
    logic [MAX_W-1:0] value;
    logic [7:0]       width;
  } entry_t;

  // Values are zero-extended to MAX_W; out-of-range indices return an empty entry.
  function automatic entry_t lookup(input logic [31:0] idx);
    entry_t e;
    e.value = '0;
    e.width = 8'd0;
    case (idx)
      32'd0: begin e.value = MAX_W'(5);                 e.width = 8'd32;  end
      32'd1: begin e.value = MAX_W'(8);                 e.width = 8'd32;  end
      32'd2: begin e.value = MAX_W'(64'h5a89901af1);    e.width = 8'd64;  end
      32'd3: begin e.value = MAX_W'(100'h5a89901af1);   e.width = 8'd100; end
      32'd4: begin e.value = MAX_W'(11);                e.width = 8'd32;  end
      32'd5: begin e.value = MAX_W'(4);                 e.width = 8'd32;  end
      default: begin e.value = '0;                      e.width = 8'd0;   end
    endcase
    return e;
  endfunction

  function automatic logic [MAX_W-1:0] width_mask(input logic [7:0] width);
    return ~({MAX_W{1'b1}} << width);
  endfunction

  function automatic int unsigned beat_count(input logic [7:0] width, input int unsigned dw);
    return (32'(width) + dw - 1) / dw;
  endfunction

endpackage

// File: rtl/pkg_const_streamer.sv
// Streams one constant-table entry per request as DATA_W-wide beats, LSB
// chunk first, over a valid/ready response channel.
module pkg_const_streamer
  import pkg_const_streamer_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int IDX_W  = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [IDX_W-1:0]  req_idx,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_last,
  output logic              rsp_err,
  output logic [15:0]       served_cnt
);

  // Handshakes: a request transfers on req_valid && req_ready, a beat on
  // rsp_valid && rsp_ready; a presented beat holds until it transfers.
  localparam int BEAT_W = $clog2(MAX_W / 8) + 1;

  state_e              state_q, state_d;
  logic [BEAT_W-1:0]   beat_q, beat_d;
  logic [BEAT_W-1:0]   last_beat_q, last_beat_d;
  logic [MAX_W-1:0]    value_q, value_d;
  logic                err_q, err_d;
  logic [15:0]         served_q, served_d;

  entry_t              entry;
  logic                idx_oob;
  logic [7:0]          shift_amt;

  always_comb begin
    entry       = lookup(32'(req_idx));
    idx_oob     = 32'(req_idx) >= NUM_ENTRIES;
    state_d     = state_q;
    beat_d      = beat_q;
    last_beat_d = last_beat_q;
    value_d     = value_q;
    err_d       = err_q;
    served_d    = served_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          state_d = ST_SEND;
          beat_d  = '0;
          if (idx_oob) begin
            value_d     = '0;
            last_beat_d = '0;
            err_d       = 1'b1;
          end else begin
            value_d     = entry.value & width_mask(entry.width);
            last_beat_d = BEAT_W'(beat_count(entry.width, DATA_W) - 1);
            err_d       = 1'b0;
          end
        end
      end
      ST_SEND: begin
        if (rsp_ready) begin
          if (beat_q == last_beat_q) begin
            state_d  = ST_IDLE;
            beat_d   = '0;
            served_d = served_q + 16'd1;
          end else begin
            beat_d = beat_q + BEAT_W'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      beat_q      <= '0;
      last_beat_q <= '0;
      value_q     <= '0;
      err_q       <= 1'b0;
      served_q    <= 16'd0;
    end else begin
      state_q     <= state_d;
      beat_q      <= beat_d;
      last_beat_q <= last_beat_d;
      value_q     <= value_d;
      err_q       <= err_d;
      served_q    <= served_d;
    end
  end

  // Outputs are gated by SEND so stale latched data never leaks in IDLE.
  always_comb begin
    shift_amt  = 8'(beat_q) * 8'(DATA_W);
    req_ready  = (state_q == ST_IDLE);
    rsp_valid  = (state_q == ST_SEND);
    rsp_data   = '0;
    rsp_last   = 1'b0;
    rsp_err    = 1'b0;
    if (state_q == ST_SEND) begin
      rsp_data = DATA_W'(value_q >> shift_amt);
      rsp_last = (beat_q == last_beat_q);
      rsp_err  = err_q;
    end
    served_cnt = served_q;
  end

endmodule

// File: tb/tb_pkg_const_streamer.sv
// Directed bench for pkg_const_streamer at DATA_W=32 and DATA_W=8 with a
// beat scoreboard fed when each request is issued.
module tb_pkg_const_streamer;

  logic        clk = 1'b0;
  logic        rst;

  logic        req_valid32, req_ready32, rsp_valid32, rsp_ready32, rsp_last32, rsp_err32;
  logic [2:0]  req_idx32;
  logic [31:0] rsp_data32;
  logic [15:0] served32;

  logic        req_valid8, req_ready8, rsp_valid8, rsp_ready8, rsp_last8, rsp_err8;
  logic [2:0]  req_idx8;
  logic [7:0]  rsp_data8;
  logic [15:0] served8;

  int          n_pass = 0;
  int          n_total = 0;
  logic [65:0] exp_q[$];

  always #5 clk = ~clk;

  pkg_const_streamer #(.DATA_W(32), .IDX_W(3)) dut32 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid32), .req_ready(req_ready32), .req_idx(req_idx32),
    .rsp_valid(rsp_valid32), .rsp_ready(rsp_ready32), .rsp_data(rsp_data32),
    .rsp_last(rsp_last32), .rsp_err(rsp_err32), .served_cnt(served32)
  );

  pkg_const_streamer #(.DATA_W(8), .IDX_W(3)) dut8 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid8), .req_ready(req_ready8), .req_idx(req_idx8),
    .rsp_valid(rsp_valid8), .rsp_ready(rsp_ready8), .rsp_data(rsp_data8),
    .rsp_last(rsp_last8), .rsp_err(rsp_err8), .served_cnt(served8)
  );

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  function automatic logic [63:0] o_data(input bit u8);
    return u8 ? 64'(rsp_data8) : 64'(rsp_data32);
  endfunction
  function automatic logic o_valid(input bit u8);
    return u8 ? rsp_valid8 : rsp_valid32;
  endfunction
  function automatic logic o_last(input bit u8);
    return u8 ? rsp_last8 : rsp_last32;
  endfunction
  function automatic logic o_err(input bit u8);
    return u8 ? rsp_err8 : rsp_err32;
  endfunction
  function automatic logic o_ready(input bit u8);
    return u8 ? req_ready8 : req_ready32;
  endfunction

  task automatic set_ready(input bit u8, input logic v);
    if (u8) rsp_ready8 = v;
    else    rsp_ready32 = v;
  endtask

  task automatic push_beat(input logic [63:0] data, input logic last, input logic err);
    exp_q.push_back({err, last, data});
  endtask

  // Reference table, written independently from the design package.
  task automatic push_model(input int idx, input int dw);
    logic [127:0] v, s;
    int w, n;
    logic [63:0] d;
    case (idx)
      0: begin v = 128'd5;            w = 32;  end
      1: begin v = 128'd8;            w = 32;  end
      2: begin v = 128'h5a89901af1;   w = 64;  end
      3: begin v = 128'h5a89901af1;   w = 100; end
      4: begin v = 128'd11;           w = 32;  end
      5: begin v = 128'd4;            w = 32;  end
      default: begin v = '0;          w = 0;   end
    endcase
    if (w == 0) begin
      push_beat(64'd0, 1'b1, 1'b1);
    end else begin
      n = (w + dw - 1) / dw;
      for (int k = 0; k < n; k++) begin
        s = v >> (k * dw);
        d = (dw == 8) ? 64'(s[7:0]) : 64'(s[31:0]);
        push_beat(d, (k == n - 1), 1'b0);
      end
    end
  endtask

  task automatic request(input bit u8, input logic [2:0] idx);
    if (u8) begin req_valid8 = 1'b1; req_idx8 = idx; end
    else    begin req_valid32 = 1'b1; req_idx32 = idx; end
    check("req_ready_idle", 64'(o_ready(u8)), 64'd1);
    tick();
    if (u8) begin req_valid8 = 1'b0; req_idx8 = 3'($urandom_range(0, 7)); end
    else    begin req_valid32 = 1'b0; req_idx32 = 3'($urandom_range(0, 7)); end
    check("first_beat_latency", 64'(o_valid(u8)), 64'd1);
  endtask

  task automatic collect(input bit u8, input int stall, input int max_beats);
    int beats = 0;
    logic [65:0] e;
    while (exp_q.size() > 0 && beats < max_beats) begin
      int waitc = 0;
      while (o_valid(u8) !== 1'b1 && waitc < 20) begin
        tick();
        waitc++;
      end
      if (o_valid(u8) !== 1'b1) begin
        check("rsp_valid_timeout", 64'(o_valid(u8)), 64'd1);
        exp_q.delete();
        return;
      end
      e = exp_q.pop_front();
      if (beats == 0) begin
        for (int i = 0; i < stall; i++) begin
          set_ready(u8, 1'b0);
          check("hold_data", o_data(u8), e[63:0]);
          check("hold_last", 64'(o_last(u8)), 64'(e[64]));
          check("hold_err", 64'(o_err(u8)), 64'(e[65]));
          tick();
        end
      end
      check("beat_data", o_data(u8), e[63:0]);
      check("beat_last", 64'(o_last(u8)), 64'(e[64]));
      check("beat_err", 64'(o_err(u8)), 64'(e[65]));
      set_ready(u8, 1'b1);
      tick();
      set_ready(u8, 1'b0);
      beats++;
    end
  endtask

  task automatic check_done(input bit u8, input int exp_served);
    check("idle_gap_valid", 64'(o_valid(u8)), 64'd0);
    check("idle_gap_ready", 64'(o_ready(u8)), 64'd1);
    check("served_cnt", u8 ? 64'(served8) : 64'(served32), 64'(exp_served));
  endtask

  initial begin
    rst = 1'b1;
    req_valid32 = 1'b0; req_idx32 = 3'd0; rsp_ready32 = 1'b0;
    req_valid8  = 1'b0; req_idx8  = 3'd0; rsp_ready8  = 1'b0;
    tick();
    tick();
    for (int u = 0; u < 2; u++) begin
      check("rst_valid", 64'(o_valid(u == 1)), 64'd0);
      check("rst_ready", 64'(o_ready(u == 1)), 64'd1);
      check("rst_data", o_data(u == 1), 64'd0);
      check("rst_last", 64'(o_last(u == 1)), 64'd0);
      check("rst_err", 64'(o_err(u == 1)), 64'd0);
      check("rst_served", (u == 1) ? 64'(served8) : 64'(served32), 64'd0);
    end
    rst = 1'b0;
    tick();

    push_beat(64'h5, 1'b1, 1'b0);
    request(1'b0, 3'd0);
    collect(1'b0, 0, 99);
    check_done(1'b0, 1);

    push_beat(64'h89901af1, 1'b0, 1'b0);
    push_beat(64'h0000005a, 1'b0, 1'b0);
    push_beat(64'h00000000, 1'b0, 1'b0);
    push_beat(64'h00000000, 1'b1, 1'b0);
    request(1'b0, 3'd3);
    collect(1'b0, 0, 99);
    check_done(1'b0, 2);

    push_beat(64'h89901af1, 1'b0, 1'b0);
    push_beat(64'h0000005a, 1'b1, 1'b0);
    request(1'b0, 3'd2);
    collect(1'b0, 3, 99);
    check_done(1'b0, 3);

    push_beat(64'h0, 1'b1, 1'b1);
    request(1'b0, 3'd7);
    collect(1'b0, 0, 99);
    check_done(1'b0, 4);
    push_beat(64'h0000000b, 1'b1, 1'b0);
    request(1'b0, 3'd4);
    collect(1'b0, 0, 99);
    check_done(1'b0, 5);

    for (int i = 0; i < 8; i++) begin
      push_model(i, 32);
      request(1'b0, 3'(i));
      collect(1'b0, $urandom_range(0, 2), 99);
      check_done(1'b0, 6 + i);
    end

    push_model(3, 32);
    request(1'b0, 3'd3);
    collect(1'b0, 0, 2);
    rst = 1'b1;
    tick();
    check("midrst_valid", 64'(rsp_valid32), 64'd0);
    check("midrst_served", 64'(served32), 64'd0);
    check("midrst_ready", 64'(req_ready32), 64'd1);
    check("midrst_data", 64'(rsp_data32), 64'd0);
    check("midrst_last", 64'(rsp_last32), 64'd0);
    rst = 1'b0;
    exp_q.delete();
    rsp_ready32 = 1'b1;
    tick();
    tick();
    rsp_ready32 = 1'b0;
    check("postrst_valid", 64'(rsp_valid32), 64'd0);
    check("postrst_served", 64'(served32), 64'd0);

    push_beat(64'h04, 1'b0, 1'b0);
    push_beat(64'h00, 1'b0, 1'b0);
    push_beat(64'h00, 1'b0, 1'b0);
    push_beat(64'h00, 1'b1, 1'b0);
    request(1'b1, 3'd5);
    collect(1'b1, 1, 99);
    check_done(1'b1, 1);

    push_model(3, 8);
    request(1'b1, 3'd3);
    collect(1'b1, 0, 99);
    check_done(1'b1, 2);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/pkg_const_streamer.md
PKG_CONST_STREAMER -- requirements
Module: pkg_const_streamer

Interface
REQ-001 The module SHALL have parameter DATA_W, default 32, meaning output beat width in bits; legal values 8, 16, 32, 64.
REQ-002 The module SHALL have parameter IDX_W, default 3, meaning request index width.
REQ-003 The module SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 The module SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 The module SHALL have port req_valid  input  1  readout request present.
REQ-006 The module SHALL have port req_ready  output  1  request accepted when high with req_valid.
REQ-007 The module SHALL have port req_idx  input  IDX_W  constant-table entry selector.
REQ-008 The module SHALL have port rsp_valid  output  1  beat present on rsp_data.
REQ-009 The module SHALL have port rsp_ready  input  1  consumer accepts beat.
REQ-010 The module SHALL have port rsp_data  output  DATA_W  current beat, LSB chunk first.
REQ-011 The module SHALL have port rsp_last  output  1  final beat of the current entry.
REQ-012 The module SHALL have port rsp_err  output  1  request index out of range; valid with rsp_valid.
REQ-013 The module SHALL have port served_cnt  output  16  count of completed responses, wraps at 0xFFFF->0.

Function
REQ-014 The FSM SHALL have states IDLE and SEND; req_ready = 1 only in IDLE.
REQ-015 A request SHALL be accepted on req_valid && req_ready; the module latches the entry value and width, sets beat counter to 0 and enters SEND the next cycle.
REQ-016 Beat count SHALL be ceil(entry_width/DATA_W); beat k carries value bits [k*DATA_W +: DATA_W]; bits above entry_width read as 0.
REQ-017 rsp_valid SHALL be 1 throughout SEND; a beat transfers on rsp_valid && rsp_ready.
REQ-018 While rsp_valid && !rsp_ready, rsp_data, rsp_last and rsp_err SHALL hold stable.
REQ-019 rsp_last SHALL be 1 exactly on the final beat; transfer of that beat returns the FSM to IDLE and increments served_cnt by 1.
REQ-020 req_idx >= NUM_ENTRIES SHALL produce one beat with rsp_data = 0, rsp_err = 1, rsp_last = 1; served_cnt still increments.
REQ-021 Latency from request acceptance to first rsp_valid SHALL be 1 cycle; the minimum gap between back-to-back responses SHALL be 1 IDLE cycle.
REQ-022 req_idx changes after acceptance SHALL NOT affect the response in flight.

Reset
REQ-023 rst SHALL force IDLE, beat counter 0, served_cnt 0, rsp_valid 0, rsp_last 0, rsp_err 0, rsp_data 0, req_ready 1 on the next rising edge.
REQ-024 rst asserted mid-SEND SHALL abandon the response with no further beats and no served_cnt increment.

Structure
REQ-025 The shared package pkg_const_streamer_pkg SHALL hold MAX_W = 128, NUM_ENTRIES = 6, and the table of values and widths. Entry 0 = 5 (32 b), entry 1 = 8 (32 b), entry 2 = 64'h5a89901af1 (64 b), entry 3 = 100'h5a89901af1 (100 b), entry 4 = 11 (32 b), entry 5 = 4 (32 b). Values SHALL be zero-extended to MAX_W.
REQ-026 The package SHALL provide the FSM state enum and a lookup function returning value and width by index; no sub-module is used.
REQ-027 Beat counter width SHALL be $clog2(MAX_W/8)+1 so every legal DATA_W fits.

Verification
REQ-028 The bench SHALL cover, with DATA_W=32: req idx 0 -> one beat 0x00000005, last=1, err=0, served_cnt 0->1.
REQ-029 The bench SHALL cover, with DATA_W=32: idx 3 -> beats 0x89901af1, 0x0000005a, 0x00000000, 0x00000000, with last only on beat 4.
REQ-030 The bench SHALL cover, with DATA_W=32: idx 2 with rsp_ready low for 3 cycles on beat 0 -> 0x89901af1 held stable, then 0x0000005a last.
REQ-031 The bench SHALL cover, with DATA_W=32: idx 7 -> one beat data 0, err=1, last=1; a following idx 4 request -> 0x0000000b, err=0.
REQ-032 The bench SHALL cover, with DATA_W=32: rst after beat 1 of idx 3 -> rsp_valid 0 next cycle, served_cnt 0, req_ready 1.
REQ-033 The bench SHALL cover, with DATA_W=8: idx 5 -> beats 0x04, 0x00, 0x00, 0x00, with last on beat 4.
